// File: rtl/nap_pkg.sv
// Shared types and constants for the nap timer family (stopwatch and countdown).
package nap_pkg;

    // One BCD digit, shared with the countdown timer.
    typedef logic [3:0] bcd_digit_t;

    // Stopwatch control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_t;

    // Largest value of a units digit and of a tens-of-minutes/seconds digit.
    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd_digit_t BCD_MAX_TENS  = 4'd5;

    // True when a digit lies within 0..max.
    function automatic logic bcd_digit_ok(input bcd_digit_t d, input bcd_digit_t max);
        return (d <= max);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter: counts 0..max on enable, synchronous clear wins.
// Exposes the next value so the parent can compare the post-increment count.
module bcd_digit_counter
    import nap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  bcd_digit_t max,
    output bcd_digit_t digit,
    output bcd_digit_t digit_next,
    output logic       carry
);

    bcd_digit_t digit_r;
    bcd_digit_t digit_s;

    // Next digit value: clear, roll over at max, increment, or hold.
    always_comb begin
        digit_s = digit_r;
        if (clr) begin
            digit_s = 4'd0;
        end else if (en) begin
            if (digit_r == max) begin
                digit_s = 4'd0;
            end else begin
                digit_s = digit_r + 4'd1;
            end
        end else begin
            digit_s = digit_r;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_r <= 4'd0;
        end else begin
            digit_r <= digit_s;
        end
    end

    assign digit      = digit_r;
    assign digit_next = digit_s;
    assign carry      = en && (digit_r == max);

endmodule

// File: rtl/nap_stopwatch.sv
// Count-up HH:MM:SS stopwatch in BCD with tick prescaler, limit detect and
// hour wrap at HOUR_LIMIT.
module nap_stopwatch
    import nap_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int HOUR_LIMIT = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [3:0] limHour10,
    input  logic [3:0] limHour1,
    input  logic [3:0] limMinute10,
    input  logic [3:0] limMinute1,
    input  logic [3:0] limSecond10,
    input  logic [3:0] limSecond1,
    output logic [3:0] getHour10,
    output logic [3:0] getHour1,
    output logic [3:0] getMinute10,
    output logic [3:0] getMinute1,
    output logic [3:0] getSecond10,
    output logic [3:0] getSecond1,
    output logic       running,
    output logic       done,
    output logic       wrap
);

    localparam int         HOUR_TOP    = HOUR_LIMIT - 1;
    localparam bcd_digit_t HOUR_TOP_10 = 4'(HOUR_TOP / 10);
    localparam bcd_digit_t HOUR_TOP_1  = 4'(HOUR_TOP % 10);
    localparam logic [7:0] PRESC_TOP   = 8'(TICK_DIV - 1);

    sw_state_t  state_r;
    sw_state_t  state_s;
    logic [7:0] presc_r;
    logic [7:0] presc_s;
    logic       running_r;
    logic       done_r;
    logic       wrap_r;

    logic       tick_ok_s;
    logic       sec_step_s;
    logic       hour_wrap_s;
    logic       hour_clr_s;
    logic       at_hour_top_s;
    logic       lim_ok_s;
    logic       limit_hit_s;
    logic [23:0] next_cnt_s;
    logic [23:0] lim_s;

    logic c_s1_s, c_s10_s, c_m1_s, c_m10_s, c_h1_s, c_h10_s;
    bcd_digit_t s1_n_s, s10_n_s, m1_n_s, m10_n_s, h1_n_s, h10_n_s;

    // A tick only counts in RUN when no higher-priority input is present.
    assign tick_ok_s  = (state_r == ST_RUN) && !clear && !stop && !start && tick;
    assign sec_step_s = tick_ok_s && (presc_r == PRESC_TOP);

    // Hour pair wraps after HOUR_LIMIT-1; a carry out of the pair also wraps.
    assign at_hour_top_s = (getHour10 == HOUR_TOP_10) && (getHour1 == HOUR_TOP_1);
    assign hour_wrap_s   = c_m10_s && (at_hour_top_s || c_h10_s);
    assign hour_clr_s    = clear || hour_wrap_s;

    bcd_digit_counter u_s1 (
        .clk(clock), .rst_n(reset), .clr(clear), .en(sec_step_s), .max(BCD_MAX_DIGIT),
        .digit(getSecond1), .digit_next(s1_n_s), .carry(c_s1_s)
    );
    bcd_digit_counter u_s10 (
        .clk(clock), .rst_n(reset), .clr(clear), .en(c_s1_s), .max(BCD_MAX_TENS),
        .digit(getSecond10), .digit_next(s10_n_s), .carry(c_s10_s)
    );
    bcd_digit_counter u_m1 (
        .clk(clock), .rst_n(reset), .clr(clear), .en(c_s10_s), .max(BCD_MAX_DIGIT),
        .digit(getMinute1), .digit_next(m1_n_s), .carry(c_m1_s)
    );
    bcd_digit_counter u_m10 (
        .clk(clock), .rst_n(reset), .clr(clear), .en(c_m1_s), .max(BCD_MAX_TENS),
        .digit(getMinute10), .digit_next(m10_n_s), .carry(c_m10_s)
    );
    bcd_digit_counter u_h1 (
        .clk(clock), .rst_n(reset), .clr(hour_clr_s), .en(c_m10_s), .max(BCD_MAX_DIGIT),
        .digit(getHour1), .digit_next(h1_n_s), .carry(c_h1_s)
    );
    bcd_digit_counter u_h10 (
        .clk(clock), .rst_n(reset), .clr(hour_clr_s), .en(c_h1_s), .max(BCD_MAX_DIGIT),
        .digit(getHour10), .digit_next(h10_n_s), .carry(c_h10_s)
    );

    // Limit is usable only if every digit is legal BCD for its position and it is nonzero.
    assign lim_s    = {limHour10, limHour1, limMinute10, limMinute1, limSecond10, limSecond1};
    assign lim_ok_s = bcd_digit_ok(limHour10,   BCD_MAX_DIGIT)
                   && bcd_digit_ok(limHour1,    BCD_MAX_DIGIT)
                   && bcd_digit_ok(limMinute10, BCD_MAX_TENS)
                   && bcd_digit_ok(limMinute1,  BCD_MAX_DIGIT)
                   && bcd_digit_ok(limSecond10, BCD_MAX_TENS)
                   && bcd_digit_ok(limSecond1,  BCD_MAX_DIGIT)
                   && (lim_s != 24'd0);
    assign next_cnt_s  = {h10_n_s, h1_n_s, m10_n_s, m1_n_s, s10_n_s, s1_n_s};
    assign limit_hit_s = sec_step_s && lim_ok_s && (next_cnt_s == lim_s);

    // Prescaler: cleared by clear, advanced by qualifying ticks, wraps at TICK_DIV-1.
    always_comb begin
        presc_s = presc_r;
        if (clear) begin
            presc_s = 8'd0;
        end else if (tick_ok_s) begin
            if (presc_r == PRESC_TOP) begin
                presc_s = 8'd0;
            end else begin
                presc_s = presc_r + 8'd1;
            end
        end else begin
            presc_s = presc_r;
        end
    end

    // Next-state logic with priority clear > stop > start.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear || stop) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_s = ST_IDLE;
                end else if (stop) begin
                    state_s = ST_PAUSE;
                end else if (limit_hit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_s = ST_IDLE;
                end else if (stop) begin
                    state_s = ST_PAUSE;
                end else if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, prescaler and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            presc_r   <= 8'd0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            running_r <= (state_s == ST_RUN);
            done_r    <= (state_s == ST_DONE);
            wrap_r    <= hour_wrap_s;
        end
    end

    assign running = running_r;
    assign done    = done_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_nap_stopwatch.sv
// Directed self-checking bench: dut_a (TICK_DIV=1, HOUR_LIMIT=2), dut_b (TICK_DIV=4).
module tb_nap_stopwatch;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        tick_a = 1'b0, start_a = 1'b0, stop_a = 1'b0, clear_a = 1'b0;
    logic [23:0] lim_a  = 24'h000000;
    wire  [23:0] cnt_a;
    wire         running_a, done_a, wrap_a;

    logic        tick_b = 1'b0, start_b = 1'b0, stop_b = 1'b0, clear_b = 1'b0;
    logic [23:0] lim_b  = 24'h000000;
    wire  [23:0] cnt_b;
    wire         running_b, done_b, wrap_b;

    int n_checks = 0;
    int n_errors = 0;

    nap_stopwatch #(.TICK_DIV(1), .HOUR_LIMIT(2)) dut_a (
        .clock(clock), .reset(reset), .tick(tick_a), .start(start_a), .stop(stop_a), .clear(clear_a),
        .limHour10(lim_a[23:20]), .limHour1(lim_a[19:16]), .limMinute10(lim_a[15:12]),
        .limMinute1(lim_a[11:8]), .limSecond10(lim_a[7:4]), .limSecond1(lim_a[3:0]),
        .getHour10(cnt_a[23:20]), .getHour1(cnt_a[19:16]), .getMinute10(cnt_a[15:12]),
        .getMinute1(cnt_a[11:8]), .getSecond10(cnt_a[7:4]), .getSecond1(cnt_a[3:0]),
        .running(running_a), .done(done_a), .wrap(wrap_a)
    );

    nap_stopwatch #(.TICK_DIV(4), .HOUR_LIMIT(99)) dut_b (
        .clock(clock), .reset(reset), .tick(tick_b), .start(start_b), .stop(stop_b), .clear(clear_b),
        .limHour10(lim_b[23:20]), .limHour1(lim_b[19:16]), .limMinute10(lim_b[15:12]),
        .limMinute1(lim_b[11:8]), .limSecond10(lim_b[7:4]), .limSecond1(lim_b[3:0]),
        .getHour10(cnt_b[23:20]), .getHour1(cnt_b[19:16]), .getMinute10(cnt_b[15:12]),
        .getMinute1(cnt_b[11:8]), .getSecond10(cnt_b[7:4]), .getSecond1(cnt_b[3:0]),
        .running(running_b), .done(done_b), .wrap(wrap_b)
    );

    // Count one comparison and report a mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Apply n consecutive ticks to dut_a.
    task automatic run_ticks_a(input int n);
        for (int i = 0; i < n; i++) begin
            tick_a = 1'b1;
            cyc();
        end
        tick_a = 1'b0;
    endtask

    // Apply n consecutive ticks to dut_b.
    task automatic run_ticks_b(input int n);
        for (int i = 0; i < n; i++) begin
            tick_b = 1'b1;
            cyc();
        end
        tick_b = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clock);
        #1;
        check("rst_cnt", cnt_a, 24'h000000);
        check("rst_run", running_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_wrap", wrap_a, 1'b0);
        reset = 1'b1;
        cyc();

        // Start with coincident tick: tick not counted
        start_a = 1'b1; tick_a = 1'b1;
        cyc();
        start_a = 1'b0; tick_a = 1'b0;
        check("start_tick_cnt", cnt_a, 24'h000000);
        check("start_run", running_a, 1'b1);
        run_ticks_a(3);
        check("three_ticks", cnt_a, 24'h000003);

        // Stop with coincident tick: discarded, PAUSE
        stop_a = 1'b1; tick_a = 1'b1;
        cyc();
        stop_a = 1'b0; tick_a = 1'b0;
        check("stop_cnt", cnt_a, 24'h000003);
        check("stop_run", running_a, 1'b0);
        run_ticks_a(2);
        check("pause_hold", cnt_a, 24'h000003);

        // Resume to 00:12:34 then async reset mid-RUN
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        run_ticks_a(751);
        check("pre_reset_cnt", cnt_a, 24'h001234);
        check("pre_reset_run", running_a, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_cnt", cnt_a, 24'h000000);
        check("async_rst_run", running_a, 1'b0);
        check("async_rst_done", done_a, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();

        // Minute-to-hour carry, then hour wrap at HOUR_LIMIT=2
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        run_ticks_a(3599);
        check("to_005959", cnt_a, 24'h005959);
        run_ticks_a(1);
        check("to_010000", cnt_a, 24'h010000);
        run_ticks_a(3599);
        check("to_015959", cnt_a, 24'h015959);
        check("no_wrap_yet", wrap_a, 1'b0);
        run_ticks_a(1);
        check("wrap_cnt", cnt_a, 24'h000000);
        check("wrap_pulse", wrap_a, 1'b1);
        check("wrap_run", running_a, 1'b1);
        cyc();
        check("wrap_one_cycle", wrap_a, 1'b0);
        check("wrap_hold_cnt", cnt_a, 24'h000000);

        // Limit 00:00:05
        clear_a = 1'b1;
        cyc();
        clear_a = 1'b0;
        check("clear_run", running_a, 1'b0);
        run_ticks_a(2);
        check("idle_ignores_tick", cnt_a, 24'h000000);
        lim_a = 24'h000005;
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        run_ticks_a(4);
        check("lim_cnt4", cnt_a, 24'h000004);
        check("lim_done4", done_a, 1'b0);
        run_ticks_a(1);
        check("lim_cnt5", cnt_a, 24'h000005);
        check("lim_done5", done_a, 1'b1);
        check("lim_run5", running_a, 1'b0);
        start_a = 1'b1;
        run_ticks_a(3);
        start_a = 1'b0;
        check("done_hold_cnt", cnt_a, 24'h000005);
        check("done_hold_flag", done_a, 1'b1);
        check("done_hold_run", running_a, 1'b0);
        clear_a = 1'b1; tick_a = 1'b1;
        cyc();
        clear_a = 1'b0; tick_a = 1'b0;
        check("done_clear_cnt", cnt_a, 24'h000000);
        check("done_clear_flag", done_a, 1'b0);
        check("done_clear_run", running_a, 1'b0);

        // Unreachable limit (Second10=7) never fires
        lim_a = 24'h000170;
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        run_ticks_a(80);
        check("bad_lim_cnt", cnt_a, 24'h000120);
        check("bad_lim_done", done_a, 0);
        run_ticks_a(5);
        check("bad_lim_past", cnt_a, 24'h000125);
        // Limit lowered below count: no match
        lim_a = 24'h000010;
        run_ticks_a(5);
        check("low_lim_cnt", cnt_a, 24'h000130);
        check("low_lim_done", done_a, 1'b0);
        check("low_lim_run", running_a, 1'b1);

        // TICK_DIV=4 prescaler, retained across PAUSE
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        run_ticks_b(7);
        check("div4_cnt1", cnt_b, 24'h000001);
        stop_b = 1'b1;
        cyc();
        stop_b = 1'b0;
        check("div4_pause_run", running_b, 1'b0);
        run_ticks_b(2);
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        check("div4_resume_cnt", cnt_b, 24'h000001);
        check("div4_resume_run", running_b, 1'b1);
        run_ticks_b(1);
        check("div4_cnt2", cnt_b, 24'h000002);
        check("div4_done", done_b, 1'b0);
        check("div4_wrap", wrap_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nap_stopwatch.md
Name: nap_stopwatch

Overview:
- Count-up counterpart of the nap countdown timer: accumulates elapsed time as six BCD digits (HH:MM:SS) from a per-second tick.
- Raises a done flag when a programmed limit is reached.
- Feeds the display mux and the nap controller, which uses it for elapsed-time and "over-nap" alarms.

Parameters:
- TICK_DIV, 1: number of tick pulses per counted second (1..255); internal prescaler.
- HOUR_LIMIT, 99: decimal hour at which the count wraps to 00:00:00 (1..99).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- tick  in  1  one-cycle pulse from the timebase
- start  in  1  begin/resume counting
- stop  in  1  pause counting
- clear  in  1  synchronous clear to 00:00:00, IDLE
- limHour10, limHour1, limMinute10, limMinute1, limSecond10, limSecond1  in  4 each  BCD limit; all zero = no limit
- getHour10, getHour1, getMinute10, getMinute1, getSecond10, getSecond1  out  4 each  registered BCD count
- running  out  1  high in RUN
- done  out  1  level, high in DONE
- wrap  out  1  one-cycle pulse on rollover to 00:00:00

Behaviour:
- Reset (reset=0, async): all get* digits 0, prescaler 0, state IDLE, running=0, done=0, wrap=0.
- States: IDLE, RUN, PAUSE, DONE (encoding in package).
- Input priority in every state: clear > stop > start > tick.
- clear: same edge sets digits 0, prescaler 0, state IDLE, done=0. A tick in the same cycle is discarded.
- IDLE: start -> RUN. A tick in the start cycle is not counted; counting begins with the next tick.
- RUN:
  - stop -> PAUSE; a coincident tick is discarded.
  - Otherwise each tick increments the prescaler. When the prescaler reaches TICK_DIV-1 it returns to 0 and the count advances by one second.
- PAUSE: start -> RUN. Prescaler and digits hold. Ticks are ignored.
- DONE: digits hold; start and stop are ignored; only clear or reset exits.
- Increment (one second), ripple within the same edge:
  - Second1 9->0 carries to Second10.
  - Second10 5->0 carries to Minute1.
  - Minute1 9->0 carries to Minute10.
  - Minute10 5->0 carries to hours.
  - Hours are a BCD pair 00..HOUR_LIMIT-1; at HOUR_LIMIT-1:59:59 the next second gives 00:00:00, wrap=1 for exactly one cycle, and the state stays RUN.
- Latency: count update is visible on get* the cycle after the sampling edge of the qualifying tick.
- Limit compare is done on the next-count value:
  - If next count equals the limit and the limit is nonzero, the same edge loads the count, enters DONE, sets done=1 and drops running.
  - A limit containing any digit >9, or Second10/Minute10 >5, is treated as unreachable: it never matches.
- Limit inputs are sampled continuously. Changing the limit below the current count does not trigger done; only an exact match on increment does.
- Wrap and a limit match on the same increment (limit 00:00:00 excluded): not possible by construction.
- The count is always valid BCD. Out-of-range digits are unreachable, so there is no recovery path.

Decomposition:
- Package nap_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - BCD constants: digit max 9, tens-of-minutes/seconds max 5
  - 4-bit BCD digit typedef, shared with the countdown timer.
- Sub-module bcd_digit_counter, instantiated six times:
  - Inputs: enable, modulus max, clear.
  - Outputs: digit, carry-out.
  - The hour pair uses a wrap override driven by HOUR_LIMIT.

Test Plan:
- Reset mid-RUN at 00:12:34 (reset=0 for 1 cycle) -> all digits 0, running=0, done=0 immediately, without waiting for a clock edge.
- start, then 3 ticks with TICK_DIV=1 -> 00:00:03, running=1. Tick coincident with start -> not counted. Next, stop+tick same cycle -> holds 00:00:03, PAUSE.
- Preload via ticks to 00:59:59, then 1 tick -> 01:00:00 on the following cycle. At HOUR_LIMIT=2, from 01:59:59 one tick -> 00:00:00, wrap pulse exactly 1 cycle, still RUN.
- limit 00:00:05, run 5 ticks -> done=1 on the 5th update, running=0. Further ticks and start -> count stays 00:00:05. clear -> 00:00:00, IDLE, done=0.
- TICK_DIV=4: 7 ticks -> 00:00:01. Pause, start, 1 more tick -> 00:00:02 (prescaler retained across PAUSE).
- limit with limSecond10=7 -> never done; count passes 00:01:20 with done=0.
